key_expansion_seq: RTL

Iterative AES key schedule that computes one 32-bit schedule word per clock instead of unrolling the full expansion combinationally. Key size (128/192/256) is selected per run at run time. Round keys are held in an internal word store and read through an indexed round-key port by the encrypt/decrypt round engines. A single shared 4-byte S-box replaces the per-word lookup fan-out of the combinational version.

---
 rtl/key_expansion_if.sv | 27 ++
 rtl/key_expansion_seq.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/key_expansion_if.sv
// Request/status and round-key read bus of the iterative AES key schedule.
interface key_expansion_if #(
  parameter int unsigned MAX_NK = 8
) ();
  localparam int unsigned KEY_W = MAX_NK * 32;

  logic             start;
  logic [1:0]       key_size;
  logic [KEY_W-1:0] key;
  logic             busy;
  logic             done;
  logic             key_valid;
  logic             err;
  logic [3:0]       nr_out;
  logic [3:0]       rk_idx;
  logic [127:0]     rk_out;

  modport master (
    output start, key_size, key, rk_idx,
    input  busy, done, key_valid, err, nr_out, rk_out
  );

  modport slave (
    input  start, key_size, key, rk_idx,
    output busy, done, key_valid, err, nr_out, rk_out
  );
endinterface

// File: rtl/key_expansion_seq.sv
// Iterative AES key schedule: one 32-bit word per clock into a word store,
// round keys read back combinationally by index.
module key_expansion_seq #(
  parameter int unsigned MAX_NK    = 8,
  parameter int unsigned MAX_WORDS = 60
) (
  input logic            clk,
  input logic            rst_n,
  key_expansion_if.slave bus
);
  localparam int unsigned AW = $clog2(MAX_WORDS);

  typedef enum logic {IDLE, GEN} state_t;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = '0;
    x = a;
    for (int k = 0; k < 8; k++) begin
      if (b[k]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // S-box as x^254 (multiplicative inverse, 0 -> 0) followed by the affine map
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] inv;
    logic [7:0] sq;
    logic [7:0] s;
    logic [7:0] c;
    inv = 8'h01;
    sq  = x;
    c   = 8'h63;
    for (int k = 1; k < 8; k++) begin
      sq  = gf_mul(sq, sq);
      inv = gf_mul(inv, sq);
    end
    for (int b = 0; b < 8; b++)
      s[b] = inv[b] ^ inv[3'(b + 4)] ^ inv[3'(b + 5)] ^ inv[3'(b + 6)]
           ^ inv[3'(b + 7)] ^ c[b];
    return s;
  endfunction

  state_t        state_q, state_d;
  logic [3:0]    nk_q, nk_d, nr_q, nr_d;
  logic [AW-1:0] i_q, i_d;
  logic [2:0]    j_q, j_d;
  logic [7:0]    rcon_q, rcon_d;
  logic          busy_q, busy_d, done_q, done_d, err_q, err_d;
  logic          key_valid_q, key_valid_d;
  logic [3:0]    nr_out_q, nr_out_d;

  logic [31:0]   w [MAX_WORDS];
  logic          load, wr;
  logic [3:0]    nk_new;
  logic [31:0]   prev_w, old_w, sub_in, sub_out, temp, new_word;
  logic [AW-1:0] last_i, rk_base;

  always_comb begin
    case (bus.key_size)
      2'b00:   nk_new = 4'd4;
      2'b01:   nk_new = 4'd6;
      default: nk_new = 4'd8;
    endcase
  end

  // Next schedule word; the single shared 4-byte S-box serves both SubWord cases
  always_comb begin
    prev_w   = w[i_q - AW'(1)];
    old_w    = w[i_q - AW'(nk_q)];
    sub_in   = (j_q == 3'd0) ? {prev_w[23:0], prev_w[31:24]} : prev_w;
    sub_out  = {sbox(sub_in[31:24]), sbox(sub_in[23:16]),
                sbox(sub_in[15:8]),  sbox(sub_in[7:0])};
    if (j_q == 3'd0)
      temp = sub_out ^ {rcon_q, 24'h0};
    else if (nk_q == 4'd8 && j_q == 3'd4)
      temp = sub_out;
    else
      temp = prev_w;
    new_word = old_w ^ temp;
    last_i   = AW'({nr_q, 2'b11});
  end

  always_comb begin
    state_d     = state_q;
    nk_d        = nk_q;
    nr_d        = nr_q;
    i_d         = i_q;
    j_d         = j_q;
    rcon_d      = rcon_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    err_d       = 1'b0;
    key_valid_d = key_valid_q;
    nr_out_d    = nr_out_q;
    load        = 1'b0;
    wr          = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          if (bus.key_size == 2'b11) begin
            err_d = 1'b1;
          end else begin
            load        = 1'b1;
            nk_d        = nk_new;
            nr_d        = nk_new + 4'd6;
            i_d         = AW'(nk_new);
            j_d         = 3'd0;
            rcon_d      = 8'h01;
            key_valid_d = 1'b0;
            busy_d      = 1'b1;
            state_d     = GEN;
          end
        end
      end
      GEN: begin
        wr  = 1'b1;
        i_d = i_q + AW'(1);
        j_d = (j_q == 3'(nk_q - 4'd1)) ? 3'd0 : j_q + 3'd1;
        if (j_q == 3'd0) rcon_d = xtime(rcon_q);
        if (i_q == last_i) begin
          state_d     = IDLE;
          busy_d      = 1'b0;
          done_d      = 1'b1;
          key_valid_d = 1'b1;
          nr_out_d    = nr_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      nk_q        <= '0;
      nr_q        <= '0;
      i_q         <= '0;
      j_q         <= '0;
      rcon_q      <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      key_valid_q <= 1'b0;
      nr_out_q    <= '0;
    end else begin
      state_q     <= state_d;
      nk_q        <= nk_d;
      nr_q        <= nr_d;
      i_q         <= i_d;
      j_q         <= j_d;
      rcon_q      <= rcon_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
      key_valid_q <= key_valid_d;
      nr_out_q    <= nr_out_d;
    end
  end

  // Word store: cipher key words on accept, one generated word per GEN cycle
  always_ff @(posedge clk) begin
    if (load) begin
      for (int k = 0; k < int'(MAX_NK); k++)
        if (k < int'(nk_new)) w[k] <= bus.key[MAX_NK*32-1-32*k -: 32];
    end else if (wr) begin
      w[i_q] <= new_word;
    end
  end

  always_comb begin
    rk_base    = AW'({bus.rk_idx, 2'b00});
    bus.rk_out = '0;
    if (key_valid_q && bus.rk_idx <= nr_out_q)
      bus.rk_out = {w[rk_base], w[rk_base + AW'(1)],
                    w[rk_base + AW'(2)], w[rk_base + AW'(3)]};
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.err       = err_q;
  assign bus.key_valid = key_valid_q;
  assign bus.nr_out    = nr_out_q;
endmodule
